// File: rtl/wave_spawner_if.sv
// rtl/wave_spawner_if.sv - wave_spawner control inputs and progress outputs
interface wave_spawner_if;
    logic        start;
    logic        pause;
    logic [15:0] used_array;
    logic [2:0]  Summon;
    logic [3:0]  wave_num;
    logic [3:0]  spawned_cnt;
    logic        wave_active;
    logic        all_done;

    modport master (
        output start, pause, used_array,
        input  Summon, wave_num, spawned_cnt, wave_active, all_done
    );

    modport slave (
        input  start, pause, used_array,
        output Summon, wave_num, spawned_cnt, wave_active, all_done
    );
endinterface

// File: rtl/wave_spawner.sv
// rtl/wave_spawner.sv - level wave sequencer emitting Summon codes to the slot allocator
// Optional WAVE_SPEEDUP_EN: spawn gap halves with each wave index, floored at 2 cycles.
module wave_spawner #(
    parameter int SPAWN_GAP         = 32,
    parameter int WAVE_PAUSE        = 128,
    parameter int MONSTERS_PER_WAVE = 8,
    parameter int NUM_WAVES         = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    wave_spawner_if.slave bus
);
    localparam int CNT_MAX = (SPAWN_GAP > WAVE_PAUSE) ? SPAWN_GAP : WAVE_PAUSE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_CLEAR, S_PAUSE, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] reload;
    logic [3:0]    wave_num, spawned_cnt;
    logic [2:0]    summon_q;
    logic          start_ok, spawn_ok, clear_ok, pause_done, last_wave, last_spawn;
    logic [2:0]    wave_mod, base_type, spawn_type;

    always_comb begin
        start_ok   = ((state == S_IDLE) || (state == S_DONE)) && bus.start;
        spawn_ok   = (state == S_GAP) && (cnt == '0) && !bus.pause && (bus.used_array != 16'hFFFF);
        clear_ok   = (state == S_CLEAR) && (bus.used_array == 16'h0000) && !bus.pause;
        pause_done = (state == S_PAUSE) && (cnt == '0) && !bus.pause;
        last_wave  = (wave_num == 4'(NUM_WAVES - 1));
        last_spawn = ((spawned_cnt + 4'd1) == 4'(MONSTERS_PER_WAVE));
    end

    // Every fourth monster of a wave is one tier tougher, capped at type 7.
    always_comb begin
        wave_mod   = (wave_num >= 4'd14) ? 3'(wave_num - 4'd14) :
                     (wave_num >= 4'd7)  ? 3'(wave_num - 4'd7)  : wave_num[2:0];
        base_type  = wave_mod + 3'd1;
        spawn_type = base_type;
        if ((spawned_cnt[1:0] == 2'b11) && (base_type != 3'd7))
            spawn_type = base_type + 3'd1;
    end

`ifdef WAVE_SPEEDUP_EN
    logic [3:0]    reload_wave;
    logic [CW-1:0] gap_shifted;

    // The reload entering a new wave must already see the incremented index.
    always_comb begin
        reload_wave = start_ok ? 4'd0 : (pause_done ? wave_num + 4'd1 : wave_num);
        gap_shifted = CW'(SPAWN_GAP) >> reload_wave;
        reload      = (gap_shifted < CW'(2)) ? CW'(1) : gap_shifted - CW'(1);
    end
`else
    assign reload = CW'(SPAWN_GAP - 1);
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_nxt = S_GAP;
            S_GAP:          if (spawn_ok && last_spawn) state_nxt = S_CLEAR;
            S_CLEAR:        if (clear_ok) state_nxt = last_wave ? S_DONE : S_PAUSE;
            S_PAUSE:        if (pause_done) state_nxt = S_GAP;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.wave_active = (state == S_GAP) || (state == S_CLEAR);
        bus.all_done    = (state == S_DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            summon_q    <= 3'd0;
            cnt         <= '0;
            wave_num    <= 4'd0;
            spawned_cnt <= 4'd0;
        end else begin
            summon_q <= spawn_ok ? spawn_type : 3'd0;
            if (start_ok) begin
                cnt         <= reload;
                wave_num    <= 4'd0;
                spawned_cnt <= 4'd0;
            end else if (spawn_ok) begin
                cnt         <= reload;
                spawned_cnt <= spawned_cnt + 4'd1;
            end else if (clear_ok && !last_wave) begin
                cnt <= CW'(WAVE_PAUSE - 1);
            end else if (pause_done) begin
                cnt         <= reload;
                wave_num    <= wave_num + 4'd1;
                spawned_cnt <= 4'd0;
            end else if (((state == S_GAP) || (state == S_PAUSE)) && !bus.pause && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign bus.Summon      = summon_q;
    assign bus.wave_num    = wave_num;
    assign bus.spawned_cnt = spawned_cnt;
endmodule

// File: tb/tb_wave_spawner.sv
// tb/tb_wave_spawner.sv - self-checking bench for wave_spawner
module tb_wave_spawner;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    wave_spawner_if bus ();
    wave_spawner_if bus2 ();

    wave_spawner #(.SPAWN_GAP(4), .WAVE_PAUSE(5), .MONSTERS_PER_WAVE(3), .NUM_WAVES(2))
        dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    wave_spawner #(.SPAWN_GAP(2), .WAVE_PAUSE(1), .MONSTERS_PER_WAVE(15), .NUM_WAVES(15))
        dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

`ifdef WAVE_SPEEDUP_EN
    localparam int GAP1 = 2;
`else
    localparam int GAP1 = 4;
`endif

    localparam int P_IDLE = 0, P_GAP = 1, P_CLEAR = 2, P_PAUSE = 3, P_DONE = 4;

    typedef struct {
        logic        start;
        logic        pause;
        logic [15:0] used;
        logic [2:0]  summon;
        logic [3:0]  wave;
        logic [3:0]  spawned;
        logic        active;
        logic        done;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int edge_no = -1;
    int m_phase[2], m_cnt[2], m_wave[2], m_spawned[2], m_summon[2];

    function automatic int sg(int i);  return (i == 0) ? 4 : 2;  endfunction
    function automatic int wp(int i);  return (i == 0) ? 5 : 1;  endfunction
    function automatic int mpw(int i); return (i == 0) ? 3 : 15; endfunction
    function automatic int nw(int i);  return (i == 0) ? 2 : 15; endfunction

    function automatic int gap_for(int i);
`ifdef WAVE_SPEEDUP_EN
        int s = sg(i) >> m_wave[i];
        return ((s < 2) ? 2 : s) - 1;
`else
        return sg(i) - 1;
`endif
    endfunction

    function automatic int type_of(int w, int k);
        int b = (w % 7) + 1;
        if (k % 4 == 3) b = (b + 1 > 7) ? 7 : b + 1;
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, edge_no, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE; m_cnt[i] = 0; m_wave[i] = 0; m_spawned[i] = 0; m_summon[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input logic st, input logic pz, input logic [15:0] used);
        int nsum = 0;
        case (m_phase[i])
            P_IDLE, P_DONE: if (st) begin
                m_phase[i] = P_GAP; m_wave[i] = 0; m_spawned[i] = 0; m_cnt[i] = gap_for(i);
            end
            P_GAP: if (m_cnt[i] == 0 && !pz && used != 16'hFFFF) begin
                nsum = type_of(m_wave[i], m_spawned[i]);
                m_spawned[i]++;
                m_cnt[i] = gap_for(i);
                if (m_spawned[i] == mpw(i)) m_phase[i] = P_CLEAR;
            end else if (!pz && m_cnt[i] > 0) m_cnt[i]--;
            P_CLEAR: if (used == 16'h0 && !pz) begin
                if (m_wave[i] == nw(i) - 1) m_phase[i] = P_DONE;
                else begin m_phase[i] = P_PAUSE; m_cnt[i] = wp(i) - 1; end
            end
            P_PAUSE: if (!pz) begin
                if (m_cnt[i] == 0) begin
                    m_wave[i]++; m_spawned[i] = 0; m_cnt[i] = gap_for(i); m_phase[i] = P_GAP;
                end else m_cnt[i]--;
            end
            default: ;
        endcase
        m_summon[i] = nsum;
    endtask

    task automatic check_model(input int i);
        int s, w, k, a, d;
        if (i == 0) begin
            s = bus.Summon; w = bus.wave_num; k = bus.spawned_cnt; a = bus.wave_active; d = bus.all_done;
        end else begin
            s = bus2.Summon; w = bus2.wave_num; k = bus2.spawned_cnt; a = bus2.wave_active; d = bus2.all_done;
        end
        chk($sformatf("m%0d_summon", i), s, m_summon[i]);
        chk($sformatf("m%0d_wave_num", i), w, m_wave[i]);
        chk($sformatf("m%0d_spawned_cnt", i), k, m_spawned[i]);
        chk($sformatf("m%0d_wave_active", i), a, int'(m_phase[i] == P_GAP || m_phase[i] == P_CLEAR));
        chk($sformatf("m%0d_all_done", i), d, int'(m_phase[i] == P_DONE));
    endtask

    task automatic set_in(input logic st, input logic pz, input logic [15:0] used);
        bus.start = st;  bus.pause = pz;  bus.used_array = used;
        bus2.start = st; bus2.pause = pz; bus2.used_array = used;
    endtask

    task automatic step();
        @(posedge Clk);
        for (int i = 0; i < 2; i++) model_edge(i, bus.start, bus.pause, bus.used_array);
        edge_no++;
        #2;
        check_model(0);
        check_model(1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        set_in(1'b0, 1'b0, 16'h0);
        #1;
        model_reset();
        check_model(0);
        check_model(1);
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b0;
        edge_no = -1;
    endtask

    initial begin
        vec_t tbl[15];
        int   se[4];
        int   ns, first, nz, r_edge, n0, n1, r;
        bit   found;
        logic [15:0] used;

        tbl = '{
            '{1'b1, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd1, 4'd0, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd1, 4'd0, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd1, 4'd0, 4'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0001, 3'd0, 4'd0, 4'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 16'h0000, 3'd0, 4'd0, 4'd3, 1'b0, 1'b0}
        };

        do_reset();
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].start, tbl[i].pause, tbl[i].used);
            step();
            chk("tbl_summon", bus.Summon, tbl[i].summon);
            chk("tbl_wave_num", bus.wave_num, tbl[i].wave);
            chk("tbl_spawned_cnt", bus.spawned_cnt, tbl[i].spawned);
            chk("tbl_wave_active", bus.wave_active, tbl[i].active);
            chk("tbl_all_done", bus.all_done, tbl[i].done);
        end

        // Full-slot stall: spawn due at edge 8 is held until the field frees at edge 21.
        do_reset();
        ns = 0;
        se = '{-1, -1, -1, -1};
        for (int e = 0; e <= 25; e++) begin
            set_in(e == 0, 1'b0, (e >= 6 && e <= 20) ? 16'hFFFF : 16'h0000);
            step();
            if (bus.Summon != 3'd0 && ns < 4) begin se[ns] = edge_no; ns++; end
        end
        chk("stall_count", ns, 3);
        chk("stall_first", se[0], 4);
        chk("stall_resume", se[1], 21);
        chk("stall_next", se[2], 25);

        for (int e = 26; e <= 35; e++) begin set_in(1'b0, 1'b0, 16'h0001); step(); end
        chk("clear_hold_active", bus.wave_active, 1);
        chk("clear_hold_wave", bus.wave_num, 0);
        set_in(1'b0, 1'b0, 16'h0000);
        step();
        chk("clear_exit_active", bus.wave_active, 0);
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin step(); if (bus.wave_num == 4'd1) found = 1; end
        chk("pause_len", edge_no, 41);
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin step(); if (bus.Summon != 3'd0) found = 1; end
        chk("w1_first_edge", edge_no, 41 + GAP1);
        chk("w1_type", bus.Summon, 2);
        first = edge_no;

        step();
        set_in(1'b0, 1'b1, 16'h0000);
        repeat (7) step();
        set_in(1'b0, 1'b0, 16'h0000);
        found = 0;
        for (int t = 0; t < 30 && !found; t++) begin step(); if (bus.Summon != 3'd0) found = 1; end
        chk("pause_delay", edge_no, first + GAP1 + 7);
        chk("pause_type", bus.Summon, 2);

        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin step(); if (bus.all_done) found = 1; end
        chk("done_reached", bus.all_done, 1);
        nz = 0;
        repeat (50) begin step(); if (bus.Summon != 3'd0 || !bus.all_done) nz++; end
        chk("done_quiet", nz, 0);

        set_in(1'b1, 1'b0, 16'h0000);
        step();
        r_edge = edge_no;
        chk("restart_wave", bus.wave_num, 0);
        chk("restart_done", bus.all_done, 0);
        set_in(1'b0, 1'b0, 16'h0000);
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin step(); if (bus.Summon != 3'd0) found = 1; end
        chk("restart_latency", edge_no - r_edge, 4);

        // Async reset while a wave-1 pulse is on the output, checked before the next edge.
        found = 0;
        for (int t = 0; t < 200 && !found; t++) begin step(); if (bus.Summon == 3'd2) found = 1; end
        chk("async_pre_summon", bus.Summon, 2);
        #1 Reset = 1'b1;
        #1;
        chk("async_summon", bus.Summon, 0);
        chk("async_wave_num", bus.wave_num, 0);
        chk("async_spawned", bus.spawned_cnt, 0);
        chk("async_active", bus.wave_active, 0);
        chk("async_done", bus.all_done, 0);
        do_reset();

        set_in(1'b1, 1'b0, 16'h0000);
        step();
        set_in(1'b0, 1'b0, 16'h0000);
        n0 = 0; n1 = 0;
        for (int t = 0; t < 2000 && !(bus.all_done && bus2.all_done); t++) begin
            step();
            if (bus.Summon != 3'd0) n0++;
            if (bus2.Summon != 3'd0) n1++;
        end
        chk("full0_spawns", n0, 6);
        chk("full1_spawns", n1, 225);
        chk("full1_done", bus2.all_done, 1);

        do_reset();
        for (int t = 0; t < 6000; t++) begin
            r = $urandom_range(0, 7);
            used = (r < 4) ? 16'h0000 : (r == 4) ? 16'hFFFF :
                   (r == 5) ? 16'($urandom) : (16'h0001 << $urandom_range(0, 15));
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, used);
            step();
            if ($urandom_range(0, 1999) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
